writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 83 ++++++++
 tb/tb_writeback_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage: commits ALU results or memory-load data to the register file
// and exposes the last committed write as a forwarding source.
module writeback_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_rd,
  input  logic [7:0] in_result,
  input  logic       in_is_load,
  input  logic       in_wen,
  output logic       mem_rd_en,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic       reg_write,
  output logic [2:0] rd,
  output logic [7:0] data_in,
  output logic       fwd_valid,
  output logic [2:0] fwd_rd,
  output logic [7:0] fwd_data,
  output logic [7:0] wb_count
);
  typedef enum logic [1:0] {IDLE, LOAD_REQ, LOAD_DATA, WRITE} state_t;
  state_t     state_q, state_d;
  logic [2:0] rd_q, rd_d;
  logic [7:0] data_q, data_d, addr_q, addr_d;
  logic       fwd_valid_q;
  logic [2:0] fwd_rd_q;
  logic [7:0] fwd_data_q, cnt_q;
  logic       hs;
  always_comb begin
    in_ready = reset && (state_q == IDLE || state_q == WRITE);
    hs       = in_valid && in_ready;
    state_d  = IDLE;
    rd_d     = rd_q;
    data_d   = data_q;
    addr_d   = addr_q;
    if (hs) begin
      rd_d    = in_rd;
      data_d  = in_result;
      addr_d  = in_result;
      state_d = !in_wen ? IDLE : in_is_load ? LOAD_REQ : WRITE;
    end else if (state_q == LOAD_REQ) begin
      state_d = LOAD_DATA;
    end else if (state_q == LOAD_DATA) begin
      state_d = WRITE;
      data_d  = mem_rdata;
    end
  end
  // Datapath outputs are forced to zero while reset is held, independent of register contents.
  assign mem_rd_en = reset && state_q == LOAD_REQ;
  assign reg_write = reset && state_q == WRITE;
  assign rd        = reset ? rd_q : '0;
  assign data_in   = reset ? data_q : '0;
  assign mem_addr  = reset ? addr_q : '0;
  assign fwd_valid = fwd_valid_q;
  assign fwd_rd    = fwd_rd_q;
  assign fwd_data  = fwd_data_q;
  assign wb_count  = cnt_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rd_q        <= '0;
      data_q      <= '0;
      addr_q      <= '0;
      fwd_valid_q <= 1'b0;
      fwd_rd_q    <= '0;
      fwd_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      if (state_q == WRITE) begin
        fwd_valid_q <= 1'b1;
        fwd_rd_q    <= rd_q;
        fwd_data_q  <= data_q;
        cnt_q       <= cnt_q + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: randomized and directed stimulus with a queue-based scoreboard
// and a reference model of the commit/forwarding state.
module tb_writeback_stage;
  logic       clk = 1'b0;
  logic       reset, in_valid, in_is_load, in_wen;
  logic       in_ready, mem_rd_en, reg_write, fwd_valid;
  logic [2:0] in_rd, rd, fwd_rd;
  logic [7:0] in_result, mem_addr, mem_rdata, data_in, fwd_data, wb_count;
  logic [7:0] tb_mem [256];
  int checks = 0, errors = 0, cyc = 0;

  typedef struct {logic [2:0] r; logic [7:0] d; int due;} wb_t;
  typedef struct {logic [7:0] a; int due;} ld_t;
  wb_t sb [$];
  ld_t lq [$];

  writeback_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_result(in_result), .in_is_load(in_is_load), .in_wen(in_wen),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .reg_write(reg_write), .rd(rd), .data_in(data_in),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .wb_count(wb_count)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  always @(posedge clk) mem_rdata <= tb_mem[mem_addr];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
  endtask

  // Offer one transaction, wait for acceptance, and record what must come out.
  task automatic issue(input logic [2:0] r, input logic [7:0] v, input logic ld, input logic we);
    bit ok = 0;
    in_valid = 1'b1; in_rd = r; in_result = v; in_is_load = ld; in_wen = we;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    chk("accept_timeout", {31'd0, ok}, 32'd1);
    if (ok && we) begin
      sb.push_back('{r, ld ? tb_mem[v] : v, cyc + (ld ? 3 : 1)});
      if (ld) lq.push_back('{v, cyc + 1});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: reference model of commit history, independent of the stimulus.
  initial begin
    logic       m_valid = 1'b0;
    logic [2:0] m_rd = '0;
    logic [7:0] m_data = '0, m_cnt = '0;
    wb_t w;
    ld_t l;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        chk("fwd_valid", fwd_valid, m_valid);
        chk("fwd_rd", fwd_rd, m_rd);
        chk("fwd_data", fwd_data, m_data);
        chk("wb_count", wb_count, m_cnt);
        if (!reset) begin
          chk("rst_outputs", {reg_write, mem_rd_en, in_ready, rd, data_in, mem_addr}, 0);
          m_valid = 0; m_rd = 0; m_data = 0; m_cnt = 0;
          sb.delete();
          lq.delete();
        end else begin
          if (mem_rd_en) begin
            if (lq.size() == 0) chk("rd_en_unexpected", mem_rd_en, 0);
            else begin
              l = lq.pop_front();
              chk("mem_addr", mem_addr, l.a);
              chk("rd_en_cycle", cyc, l.due);
            end
          end else if (lq.size() != 0 && lq[0].due <= cyc) begin
            chk("rd_en_missing", mem_rd_en, 1);
            void'(lq.pop_front());
          end
          if (reg_write) begin
            if (sb.size() == 0) chk("wb_unexpected", reg_write, 0);
            else begin
              w = sb.pop_front();
              chk("wb_rd", rd, w.r);
              chk("wb_data", data_in, w.d);
              chk("wb_cycle", cyc, w.due);
              m_valid = 1; m_rd = w.r; m_data = w.d; m_cnt = m_cnt + 8'd1;
            end
          end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            chk("wb_missing", reg_write, 1);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'($urandom);
    tb_mem[8'h20] = 8'hA7;
    reset = 1'b0; in_valid = 1'b0; in_rd = '0; in_result = '0; in_is_load = 1'b0; in_wen = 1'b0;
    idle(3);
    reset = 1'b1;
    // single ALU write
    issue(3'd1, 8'h55, 1'b0, 1'b1);
    chk("alu_wb", {reg_write, rd, data_in}, {1'b1, 3'd1, 8'h55});
    idle(1);
    chk("alu_fwd", {fwd_valid, fwd_rd, fwd_data, wb_count}, {1'b1, 3'd1, 8'h55, 8'd1});
    // load with two-cycle bubble
    issue(3'd3, 8'h20, 1'b1, 1'b1);
    chk("ld_req", {in_ready, mem_rd_en, mem_addr}, {1'b0, 1'b1, 8'h20});
    idle(1);
    chk("ld_data_ready", {in_ready, mem_rd_en}, {1'b0, 1'b0});
    idle(1);
    chk("ld_wb", {reg_write, rd, data_in}, {1'b1, 3'd3, 8'hA7});
    idle(2);
    // back-to-back ALU writes from a clean count
    do_reset();
    issue(3'd2, 8'h01, 1'b0, 1'b1);
    issue(3'd4, 8'h02, 1'b0, 1'b1);
    issue(3'd7, 8'h03, 1'b0, 1'b1);
    idle(2);
    chk("b2b_count", wb_count, 8'd3);
    // handshake without register write
    issue(3'd5, 8'h99, 1'b0, 1'b0);
    chk("nowen_wb", reg_write, 1'b0);
    idle(2);
    chk("nowen_count", {wb_count, fwd_rd, fwd_data}, {8'd3, 3'd7, 8'h03});
    // reset while waiting for load data
    issue(3'd6, 8'h44, 1'b1, 1'b1);
    idle(1);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    chk("abort_wb", reg_write, 1'b0);
    chk("abort_zero", {fwd_valid, fwd_rd, fwd_data, wb_count, rd, data_in, mem_addr}, 0);
    issue(3'd0, 8'hC3, 1'b0, 1'b1);
    chk("post_abort_wb", {reg_write, rd, data_in}, {1'b1, 3'd0, 8'hC3});
    idle(2);
    // randomized mix
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      issue(3'($urandom), 8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 4) != 0);
    end
    idle(5);
    // counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) issue(3'(i), 8'(i), 1'b0, 1'b1);
    idle(2);
    chk("wrap_count", {fwd_valid, wb_count}, {1'b1, 8'h00});
    chk("sb_drained", sb.size() + lq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
